dmem_ctrl: RTL
==============

Name: dmem_ctrl

Overview:
- Data-memory access controller directly downstream of the execute stage's load/store unit.
- Takes exe's single-cycle address/store request and drives a req/gnt/rvalid data bus. Generates byte enables and lane-replicated write data.
- Stalls the pipeline until the bus transaction completes, then returns a lane-selected, sign/zero-extended load word to exe.
- Misaligned accesses and bus timeouts are flagged instead of issued or hung.

Parameters:
XLEN, 32, data/address width; only 32 supported.
TIMEOUT_CYCLES, 255, maximum cycles spent in REQ+RESP before forced abort; must be ≥1 and < 2^16.

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
adr_v_i  input  1  exe memory access valid
adr_i  input  XLEN  byte address from exe
is_store_i  input  1  1=store, 0=load
store_data_i  input  XLEN  store data, right-aligned
access_size_i  input  3  one-hot size: 001 byte, 010 half, 100 word
unsign_extension_i  input  1  zero-extend loads when 1
flush_i  input  1  exe-side flush; blocks acceptance in IDLE only
stall_o  output  1  hold exe/dec stages
load_data_o  output  XLEN  extended load data, valid while done_o=1
done_o  output  1  one-cycle completion pulse
misalign_o  output  1  one-cycle misaligned-access pulse
bus_err_o  output  1  one-cycle timeout pulse
dmem_req_o  output  1  bus request
dmem_we_o  output  1  write enable
dmem_be_o  output  4  byte enables
dmem_adr_o  output  XLEN  word-aligned address (adr[1:0]=00)
dmem_wdata_o  output  XLEN  lane-replicated write data
dmem_gnt_i  input  1  request accepted
dmem_rvalid_i  input  1  response valid (loads and stores)
dmem_rdata_i  input  XLEN  read data word

Behaviour:
- Reset (sync, high): state=IDLE, timeout counter=0, capture registers=0. All outputs 0 one edge after reset asserts. Reset mid-transaction drops dmem_req_o at that edge; an in-flight response is ignored.
- FSM states: IDLE, REQ, RESP, DONE.
- Accept condition: state=IDLE & adr_v_i & ~flush_i & aligned.
  - Aligned means: word needs adr_i[1:0]=00; half needs adr_i[0]=0; byte is always aligned.
  - On accept, capture adr, we, size, unsign, BE and wdata, then go to REQ.
- Misaligned in IDLE (with adr_v_i & ~flush_i): no bus request; misalign_o=1 next cycle for one cycle; state stays IDLE.
- REQ: dmem_req_o=1 with all bus fields held stable from registers. On dmem_gnt_i go to RESP and drop req the same edge.
- RESP: on dmem_rvalid_i, register the extended load data (0 for stores) and go to DONE.
- rvalid is accepted only in RESP; rvalid arriving in the same cycle as gnt is ignored (bus protocol forbids it).
- DONE: done_o=1, load_data_o valid; always return to IDLE. No new acceptance occurs in DONE.
- stall_o = (IDLE & adr_v_i & ~flush_i & aligned) | REQ | RESP. stall_o is 0 in DONE, so exe samples load_data_o and advances that cycle.
- Total latency is 1 (accept) + gnt wait + rvalid wait + 1 (DONE) cycles. Minimum: accept→done is 3 cycles with gnt in the first REQ cycle and rvalid in the next.
- Timeout: the counter clears on accept and increments each cycle in REQ or RESP.
  - When it reaches TIMEOUT_CYCLES: go to DONE, drop req, bus_err_o=1 for the DONE cycle, load_data_o=0.
- flush_i has no effect outside IDLE: an issued access always completes.
- Byte enables:
  - byte: 0001<<adr[1:0]
  - half: 0011<<adr[1:0]
  - word: 1111
- Write data:
  - byte: {4{sd[7:0]}}
  - half: {2{sd[15:0]}}
  - word: sd
- Load data: select the lane by captured adr[1:0] (half lane by adr[1]), then sign-extend unless unsign=1. Word loads pass through unchanged.
- Only one outstanding transaction exists at a time.

Test Plan:
- Word load at 0x100, gnt first REQ cycle, rvalid next, rdata=0xDEADBEEF → req seen 1 cycle, be=1111, adr=0x100, stall high 3 cycles, done_o with load_data_o=0xDEADBEEF.
- Signed byte load at 0x103, rdata=0x80FF_FF00 → be=1000, load_data_o=0xFFFFFF80; same access with unsign=1 → 0x00000080.
- Half store 0x1234 at 0x202, gnt delayed 3 cycles → req held 3 cycles with stable adr=0x200, be=1100, wdata=0x12341234, we=1; done_o after rvalid.
- Word load at 0x101 → no dmem_req_o, misalign_o pulse next cycle, stall_o low.
- TIMEOUT_CYCLES=4 with gnt never asserted → req for 4 cycles, then DONE with bus_err_o=1, load_data_o=0, stall drops.
- Reset asserted in RESP, then rvalid → state IDLE, no done_o; flush_i with adr_v_i in IDLE → no accept, no stall.

Source files
------------

// File: rtl/dmem_ctrl_if.sv
// Data-memory bus bundle: req/gnt/rvalid handshake with byte enables.
// The controller side uses the master modport and the memory side uses the slave modport.
interface dmem_ctrl_if #(
    parameter int unsigned XLEN = 32
);
    logic            dmem_req;
    logic            dmem_we;
    logic [3:0]      dmem_be;
    logic [XLEN-1:0] dmem_adr;
    logic [XLEN-1:0] dmem_wdata;
    logic            dmem_gnt;
    logic            dmem_rvalid;
    logic [XLEN-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_be, dmem_adr, dmem_wdata,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_be, dmem_adr, dmem_wdata,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory access controller: turns one exe load/store into a req/gnt/rvalid bus
// transaction, stalls exe until it completes, and returns lane-selected, extended load data.
module dmem_ctrl #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            adr_v_i,
    input  logic [XLEN-1:0] adr_i,
    input  logic            is_store_i,
    input  logic [XLEN-1:0] store_data_i,
    input  logic [2:0]      access_size_i,
    input  logic            unsign_extension_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic [XLEN-1:0] load_data_o,
    output logic            done_o,
    output logic            misalign_o,
    output logic            bus_err_o,
    dmem_ctrl_if.master     dmem
);

    typedef enum logic [1:0] {StIdle, StReq, StResp, StDone} state_t;

    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

    state_t          r_state, w_state_d;
    logic [XLEN-1:0] r_adr, r_wdata, r_ldata;
    logic            r_we, r_unsign, r_err, r_misalign;
    logic [1:0]      r_size;
    logic [3:0]      r_be;
    logic [15:0]     r_cnt;

    logic            w_aligned, w_req_v, w_accept, w_misalign, w_busy, w_timeout;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_wdata, w_ext;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;

    // Size decode priority (byte, half, else word) is shared by alignment, BE and extraction.
    always_comb begin
        if (access_size_i[0]) begin
            w_aligned = 1'b1;
            w_be      = 4'b0001 << adr_i[1:0];
            w_wdata   = {4{store_data_i[7:0]}};
        end else if (access_size_i[1]) begin
            w_aligned = ~adr_i[0];
            w_be      = 4'b0011 << adr_i[1:0];
            w_wdata   = {2{store_data_i[15:0]}};
        end else begin
            w_aligned = (adr_i[1:0] == 2'b00);
            w_be      = 4'b1111;
            w_wdata   = store_data_i;
        end
    end

    assign w_req_v    = (r_state == StIdle) && adr_v_i && !flush_i;
    assign w_accept   = w_req_v && w_aligned;
    assign w_misalign = w_req_v && !w_aligned;
    assign w_busy     = (r_state == StReq) || (r_state == StResp);
    assign w_timeout  = w_busy && (r_cnt == TimeoutLast);

    always_comb begin
        w_byte = dmem.dmem_rdata[{r_adr[1:0], 3'b000} +: 8];
        w_half = dmem.dmem_rdata[{r_adr[1], 4'b0000} +: 16];
        if (r_size[0]) begin
            w_ext = {{(XLEN-8){~r_unsign & w_byte[7]}}, w_byte};
        end else if (r_size[1]) begin
            w_ext = {{(XLEN-16){~r_unsign & w_half[15]}}, w_half};
        end else begin
            w_ext = dmem.dmem_rdata;
        end
    end

    // A response in the last allowed cycle still completes normally; a late grant does not.
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (w_accept) w_state_d = StReq;
            StReq: begin
                if (w_timeout)          w_state_d = StDone;
                else if (dmem.dmem_gnt) w_state_d = StResp;
            end
            StResp: begin
                if (dmem.dmem_rvalid || w_timeout) w_state_d = StDone;
            end
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= StIdle;
            r_adr      <= '0;
            r_wdata    <= '0;
            r_ldata    <= '0;
            r_we       <= 1'b0;
            r_unsign   <= 1'b0;
            r_err      <= 1'b0;
            r_misalign <= 1'b0;
            r_size     <= '0;
            r_be       <= '0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_d;
            r_misalign <= w_misalign;
            if (w_accept) begin
                r_adr    <= adr_i;
                r_wdata  <= w_wdata;
                r_we     <= is_store_i;
                r_unsign <= unsign_extension_i;
                r_size   <= access_size_i[1:0];
                r_be     <= w_be;
                r_cnt    <= '0;
                r_err    <= 1'b0;
            end else if (w_busy) begin
                r_cnt <= r_cnt + 16'd1;
            end
            if ((r_state == StResp) && dmem.dmem_rvalid) begin
                r_ldata <= r_we ? '0 : w_ext;
                r_err   <= 1'b0;
            end else if (w_timeout) begin
                r_ldata <= '0;
                r_err   <= 1'b1;
            end
        end
    end

    assign stall_o     = w_accept || w_busy;
    assign done_o      = (r_state == StDone);
    assign bus_err_o   = (r_state == StDone) && r_err;
    assign load_data_o = (r_state == StDone) ? r_ldata : '0;
    assign misalign_o  = r_misalign;

    assign dmem.dmem_req   = (r_state == StReq);
    assign dmem.dmem_we    = r_we;
    assign dmem.dmem_be    = r_be;
    assign dmem.dmem_adr   = {r_adr[XLEN-1:2], 2'b00};
    assign dmem.dmem_wdata = r_wdata;

endmodule
